// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bit positions and scheduler FSM states.
// No logic; imported by the scheduler, its arbiter and anything driving the ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_MPY    = 3'b010;
  localparam logic [2:0] OP_AND    = 3'b011;
  localparam logic [2:0] OP_OR     = 3'b100;
  localparam logic [2:0] OP_NOT    = 3'b101;
  localparam logic [2:0] OP_SHIFTL = 3'b110;
  localparam logic [2:0] OP_SHIFTR = 3'b111;

  localparam int FLAG_ZF = 4;
  localparam int FLAG_CF = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_NF = 1;
  localparam int FLAG_MF = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_RD_BR = 3'd2,
    ST_RD_MR = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/alu_sched_arb.sv
// 2-way ALU request arbiter, combinational grant (0 cycles); never stalls, caller commits via i_take.
// Round-robin on last_grant by default; ALU_SCHED_FIXED_PRIO_EN gives req0 fixed priority.
module alu_sched_arb (
`ifndef ALU_SCHED_FIXED_PRIO_EN
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_take,
`endif
  input  logic [1:0] i_req_vld,
  output logic       o_gnt_vld,
  output logic       o_gnt_id
);

  assign o_gnt_vld = |i_req_vld;

`ifdef ALU_SCHED_FIXED_PRIO_EN
  assign o_gnt_id = ~i_req_vld[0];
`else
  logic last_grant_q, last_grant_d;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    if (&i_req_vld) begin
      o_gnt_id = ~last_grant_q;
    end else begin
      o_gnt_id = i_req_vld[1];
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (i_take) begin
      last_grant_d = o_gnt_id;
    end
  end

  // Reset to 1 so req0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

endmodule

// File: rtl/alu_sched.sv
// Shares one ALU between two requesters: accept, EXEC, BR window, MR window (MPY only), response.
// Response valid 3 (4 for MPY) cycles after accept, held until i_rsp_ready; ALU_SCHED_FIXED_PRIO_EN selects fixed priority.
module alu_sched #(
  parameter int DATA_W = 16,
  parameter int FLAG_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  input  logic [2:0]        i_req0_op,
  input  logic [DATA_W-1:0] i_req0_p,
  input  logic [DATA_W-1:0] i_req0_q,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [2:0]        i_req1_op,
  input  logic [DATA_W-1:0] i_req1_p,
  input  logic [DATA_W-1:0] i_req1_q,
  output logic              o_req1_ready,
  output logic [DATA_W-1:0] o_alu_p,
  output logic [DATA_W-1:0] o_alu_q,
  output logic [2:0]        o_alu_op,
  output logic              o_alu_en,
  output logic              o_c9,
  output logic              o_c10,
  input  logic [DATA_W-1:0] i_br,
  input  logic [DATA_W-1:0] i_mr,
  input  logic [FLAG_W-1:0] i_flags,
  output logic              o_rsp_valid,
  output logic              o_rsp_id,
  output logic [DATA_W-1:0] o_rsp_low,
  output logic [DATA_W-1:0] o_rsp_high,
  output logic [FLAG_W-1:0] o_rsp_flags,
  input  logic              i_rsp_ready
);
  import alu_pkg::*;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] p_q, p_d, q_q, q_d;
  logic [DATA_W-1:0] low_q, low_d, high_q, high_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              id_q, id_d;
  logic              gnt_vld, gnt_id, take;

  // Accepts are suppressed while reset is asserted so no ready pulse is lost.
  assign take = (state_q == ST_IDLE) && gnt_vld && !i_rst;

  alu_sched_arb u_arb (
`ifndef ALU_SCHED_FIXED_PRIO_EN
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_take    (take),
`endif
    .i_req_vld ({i_req1_valid, i_req0_valid}),
    .o_gnt_vld (gnt_vld),
    .o_gnt_id  (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    p_d     = p_q;
    q_d     = q_q;
    id_d    = id_q;
    low_d   = low_q;
    high_d  = high_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          op_d    = gnt_id ? i_req1_op : i_req0_op;
          p_d     = gnt_id ? i_req1_p  : i_req0_p;
          q_d     = gnt_id ? i_req1_q  : i_req0_q;
          id_d    = gnt_id;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC:  state_d = ST_RD_BR;
      ST_RD_BR: begin
        low_d   = i_br;
        flags_d = i_flags;
        high_d  = '0;
        state_d = (op_q == OP_MPY) ? ST_RD_MR : ST_RESP;
      end
      ST_RD_MR: begin
        high_d  = i_mr;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      p_q     <= '0;
      q_q     <= '0;
      id_q    <= 1'b0;
      low_q   <= '0;
      high_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      p_q     <= p_d;
      q_q     <= q_d;
      id_q    <= id_d;
      low_q   <= low_d;
      high_q  <= high_d;
      flags_q <= flags_d;
    end
  end

  assign o_req0_ready = take && !gnt_id;
  assign o_req1_ready = take && gnt_id;
  assign o_alu_p      = p_q;
  assign o_alu_q      = q_q;
  assign o_alu_op     = op_q;
  assign o_alu_en     = (state_q == ST_EXEC);
  assign o_c9         = (state_q == ST_RD_BR);
  assign o_c10        = (state_q == ST_RD_MR);
  assign o_rsp_valid  = (state_q == ST_RESP);
  assign o_rsp_id     = id_q;
  assign o_rsp_low    = low_q;
  assign o_rsp_high   = high_q;
  assign o_rsp_flags  = flags_q;

endmodule

// File: doc/alu_sched.md
# alu_sched

Sequencer and arbiter that shares the single ALU between two requesters (req0: control-unit execute path; req1: secondary/debug path). It accepts one operation at a time and drives the ALU operands, opcode and `ctrl_alu_en`. It then opens the C9 (BR) and, for MPY only, the C10 (MR) bus windows to collect the result and flags. The collected result is returned on a single response port with the winning requester's ID.

## Interface
Parameters:
- DATA_W, 16, operand/result width (matches ALU)
- FLAG_W, 5, flag vector width {ZF, CF, OF, NF, MF}

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_req0_valid / i_req1_valid  in  1  request valid
- i_req0_op / i_req1_op  in  3  ALU opcode
- i_req0_p, i_req0_q / i_req1_p, i_req1_q  in  DATA_W  operands
- o_req0_ready / o_req1_ready  out  1  request accepted this cycle
- o_alu_p, o_alu_q  out  DATA_W  operands to ALU
- o_alu_op  out  3  opcode to ALU
- o_alu_en  out  1  ALU BR/MR/flag update enable
- o_c9  out  1  BR bus enable
- o_c10  out  1  MR bus enable
- i_br, i_mr  in  DATA_W  ALU bus outputs; zero when the window is closed
- i_flags  in  FLAG_W  ALU flags
- o_rsp_valid  out  1  response valid
- o_rsp_id  out  1  0 = req0, 1 = req1
- o_rsp_low, o_rsp_high  out  DATA_W  BR and MR values; high is 0 for non-MPY
- o_rsp_flags  out  FLAG_W  flags captured for this operation
- i_rsp_ready  in  1  response consumer ready

## Operation
- FSM states: IDLE, EXEC, RD_BR, RD_MR, RESP.
- **IDLE**
  - If any request is valid, grant one of them.
  - Pulse the granted requester's o_reqN_ready for exactly this cycle.
  - Latch op, p, q and id.
  - Go to EXEC.
  - With no valid request, stay in IDLE.
- **EXEC**
  - Assert o_alu_en for one cycle. The ALU registers update at the end of this cycle.
  - Go to RD_BR.
- **RD_BR**
  - Assert o_c9.
  - Capture i_br into o_rsp_low and i_flags into o_rsp_flags.
  - Go to RD_MR if op == MPY (3'b010), otherwise go to RESP with o_rsp_high = 0.
- **RD_MR**
  - Assert o_c10.
  - Capture i_mr into o_rsp_high.
  - Go to RESP.
- **RESP**
  - Hold o_rsp_valid = 1 and all o_rsp_* stable until i_rsp_ready is high.
  - On the handshake, go to IDLE.
  - No request is accepted while in RESP.
- o_alu_p, o_alu_q and o_alu_op drive the latched values continuously from EXEC through RESP. They hold their last values while in IDLE.
- **Arbitration:** round-robin.
  - A last_grant bit records the most recent winner.
  - When both requests are valid, the one that is not last_grant wins.
  - When only one request is valid, it wins regardless of last_grant.
- Unrequested requesters' valid/op/p/q may change freely. A requester must hold its inputs stable until ready.
- Opcodes are passed through unmodified. All 8 encodings are legal.

## Timing
- Accept at cycle n.
- o_alu_en at n+1.
- o_c9 at n+2.
- o_c10 at n+3 (MPY only).
- o_rsp_valid at n+3 (non-MPY) or n+4 (MPY).
- Minimum spacing between two accepts: 4 cycles (non-MPY), 5 cycles (MPY).
- At most one of o_alu_en, o_c9, o_c10 is high in any cycle.
- **Reset values:** every output is 0 and state = IDLE.
  - last_grant = 1, so req0 wins the first tie.
- **Reset mid-operation** (any state):
  - Abort the operation.
  - No response is produced and no ready pulse is issued for the aborted operation.
  - Outputs are 0 in the cycle after the reset edge.
- i_rsp_ready high outside RESP is ignored.
- A request valid during RESP is held off and arbitrated in the next IDLE cycle.

## Configuration
- `ALU_SCHED_FIXED_PRIO_EN` defined: fixed priority, req0 always beats req1.
  - last_grant is not implemented.
  - req1 may starve.
- Undefined (default): round-robin as described above.

## Structure
- Shared package alu_pkg holds:
  - Opcode constants: ADD 000, SUB 001, MPY 010, AND 011, OR 100, NOT 101, SHIFTL 110, SHIFTR 111.
  - Flag bit indices: ZF 4, CF 3, OF 2, NF 1, MF 0.
  - The FSM state enum.
- One sub-module, `alu_sched_arb`:
  - 2-way grant logic plus the last_grant register.
  - Contains the fixed-priority macro switch.

## Test plan
- **ADD overflow:** req0 ADD p=0x7FFF, q=0x0001.
  - Expect o_rsp_low=0x8000, o_rsp_high=0x0000, o_rsp_flags=5'b00110, id=0.
  - o_rsp_valid exactly 3 cycles after ready.
- **MPY:** req1 MPY p=0x0100, q=0x0100.
  - Expect o_c10 pulse, o_rsp_high=0x0001, o_rsp_low=0x0000, o_rsp_flags=5'b00101, id=1.
  - o_rsp_valid 4 cycles after ready.
- **Tie after reset:** both requests valid with SHIFTR p=0x0003.
  - Expect req0 served first with low=0x0001, flags=5'b01000, then req1.
  - With `ALU_SCHED_FIXED_PRIO_EN` and req0 held valid, req1 is never granted.
- **Backpressure:** i_rsp_ready low for 5 cycles in RESP.
  - Response stays stable.
  - No o_reqN_ready pulse.
  - Accept resumes the cycle after the handshake.
- **Reset mid-op:** assert i_rst in RD_BR.
  - Next cycle all outputs are 0 and state is IDLE.
  - No response for the aborted operation.
  - A fresh ADD then completes normally.
- **Strobe exclusivity:** back-to-back random ops from both requesters.
  - Checker confirms o_alu_en, o_c9 and o_c10 are never high together.
  - Checker confirms o_c10 is high only for MPY.
